pazen_mem_arbiter: RTL and testbench
====================================

// Module: pazen_mem_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer that shares the two ports (A, B) of pazen_memory_controller between N_REQ
//  requesters (particle filter datapath units). Up to two requests are granted per cycle, one per port.
//  Same-line write conflicts are blocked. The block drives registered address, data, chip-select and
//  write-enable to the controller, and returns read data to each requester with fixed latency.
// PARAMETERS
//  N_REQ  4   number of requesters (2..8)
//  AW     8   word address width (16-bit words; addr[7:2] = 64-bit line, addr[1:0] = lane)
//  DW     16  data width
// PORTS
//  clk        in   1         system clock, all logic on rising edge
//  reset      in   1         synchronous, active-high
//  req        in   N_REQ     request i pending; held with we/addr/wdata stable until gnt[i]
//  we         in   N_REQ     1 = write, 0 = read (per requester)
//  addr       in   N_REQ*AW  word address, requester i at [i*AW +: AW]
//  wdata      in   N_REQ*DW  write data, requester i at [i*DW +: DW]
//  gnt        out  N_REQ     one-cycle grant pulse; request i is consumed this cycle
//  rvalid     out  N_REQ     read data for requester i valid (one-cycle pulse)
//  rdata      out  N_REQ*DW  read data, requester i at [i*DW +: DW]
//  A_in,B_in  out  AW        port A/B word address to the controller
//  DIA,DIB    out  DW        port A/B write data
//  CSA,CSB    out  1         port A/B select (1 = access this cycle)
//  WEAN,WEBN  out  1         port A/B write enable, active low
//  DOA,DOB    in   DW        port A/B read data from the controller
// BEHAVIOUR
//  Reset: gnt=0, rvalid=0, rdata=0, A_in/B_in=0, DIA/DIB=0, CSA/CSB=0, WEAN/WEBN=1, rr_ptr=0,
//    read-return pipeline cleared.
//  Arbitration (cycle T, combinational on req):
//   - Scan requesters from rr_ptr upward, modulo N_REQ. First asserted req -> port A.
//   - Continue the scan for the next asserted req -> port B, unless it conflicts.
//   - Conflict: same addr[7:2] as the port-A winner with either access a write. The conflicting request is
//     skipped this cycle and the scan continues for another port-B candidate.
//   - Two reads of the same line or the same word are allowed together.
//   - gnt[i]=1 in T for each winner. rr_ptr <= (index of last winner + 1) mod N_REQ. No grant: rr_ptr holds.
//  Issue (cycle T+1, registered):
//   - CSx=1, x_in=addr, Dxx=wdata, WExN=~we for the winner of each port.
//   - Unused port: CSx=0, WExN=1, address and data hold their previous value.
//  Read return:
//   - Controller read data is sampled at the end of T+1.
//   - rvalid[i]=1 and rdata slice i updated in T+2. Grant-to-rvalid latency is fixed at 2 cycles.
//   - rdata slice holds its value until the next read for i. Writes never assert rvalid.
//  Throughput: back-to-back grants to the same requester are allowed. A requester holding req continuously
//    is granted at least once every N_REQ cycles (fairness bound).
//  Ordering: a read granted in the cycle after a write to the same word returns the new data, because the
//    write completes in its issue cycle.
//  Single requester: always on port A. Port B is used only when two or more requests are eligible.
//  Reset mid-operation: in-flight reads are dropped (no rvalid) and pending requests must be re-presented.
// TESTING
//  1. Reset held 3 cycles with req=4'b1111 -> gnt=0, CSA=CSB=0, WEAN=WEBN=1, rvalid=0 throughout.
//  2. Req0 write addr=8'd45 data=16'hBEEF; next cycle req0 read addr=8'd45
//     -> rvalid[0] 2 cycles after the second gnt, rdata0=16'hBEEF, A_in=45 on the issue cycle.
//  3. req=4'b1111, all reads to distinct lines, held 8 cycles -> 2 grants/cycle in order {0,1},{2,3},{0,1}...,
//     16 rvalid pulses, each 2 cycles after its gnt.
//  4. Req1 write addr=8'd8 and req2 read addr=8'd10 (same line 2) in the same cycle, rr_ptr=0 -> gnt=0010
//     only (req1 on port A); gnt=0100 next cycle; CSB=0 in the first issue cycle.
//  5. Req0 and req3 both read addr=8'd250 -> both granted in one cycle (A and B), rdata0 == rdata3.
//  6. Reset asserted in the cycle after a read grant -> no rvalid produced; rr_ptr=0 afterwards,
//     so the first grant after reset goes to the lowest requester.

Source files
------------

// File: rtl/pazen_mem_arbiter.sv
// Round-robin arbiter sharing the two controller ports (A, B) among N_REQ requesters.
// Grants up to two requests per cycle, registers the issue, and returns read data two cycles after the grant.
module pazen_mem_arbiter #(
  parameter int N_REQ = 4,
  parameter int AW    = 8,
  parameter int DW    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    we,
  input  logic [N_REQ*AW-1:0] addr,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    rvalid,
  output logic [N_REQ*DW-1:0] rdata,
  output logic [AW-1:0]       A_in,
  output logic [AW-1:0]       B_in,
  output logic [DW-1:0]       DIA,
  output logic [DW-1:0]       DIB,
  output logic                CSA,
  output logic                CSB,
  output logic                WEAN,
  output logic                WEBN,
  input  logic [DW-1:0]       DOA,
  input  logic [DW-1:0]       DOB
);
  localparam int IW = $clog2(N_REQ);

  logic [IW-1:0] rr_ptr, idx, a_idx, b_idx, last_idx;
  logic          a_hit, b_hit;
  logic          rd_a, rd_b;
  logic [IW-1:0] rd_a_idx, rd_b_idx;

  function automatic logic [AW-3:0] line_of(input logic [N_REQ*AW-1:0] v, input logic [IW-1:0] i);
    return v[32'(i)*AW + 2 +: AW-2];
  endfunction

  // A single scan from rr_ptr: first hit takes port A, the first later non-conflicting hit takes port B.
  always_comb begin
    a_hit = 1'b0;
    b_hit = 1'b0;
    a_idx = '0;
    b_idx = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = IW'((32'(rr_ptr) + k) % N_REQ);
      if (req[idx]) begin
        if (!a_hit) begin
          a_hit = 1'b1;
          a_idx = idx;
        end else if (!b_hit &&
                     !((line_of(addr, idx) == line_of(addr, a_idx)) && (we[idx] || we[a_idx]))) begin
          b_hit = 1'b1;
          b_idx = idx;
        end
      end
    end
    last_idx = b_hit ? b_idx : a_idx;
  end

  always_comb begin
    gnt = '0;
    if (!reset && a_hit) gnt[a_idx] = 1'b1;
    if (!reset && b_hit) gnt[b_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      CSA      <= 1'b0;
      CSB      <= 1'b0;
      WEAN     <= 1'b1;
      WEBN     <= 1'b1;
      A_in     <= '0;
      B_in     <= '0;
      DIA      <= '0;
      DIB      <= '0;
      rd_a     <= 1'b0;
      rd_b     <= 1'b0;
      rd_a_idx <= '0;
      rd_b_idx <= '0;
      rvalid   <= '0;
      rdata    <= '0;
    end else begin
      if (a_hit) rr_ptr <= IW'((32'(last_idx) + 1) % N_REQ);

      CSA  <= a_hit;
      WEAN <= ~(a_hit & we[a_idx]);
      if (a_hit) begin
        A_in <= addr[32'(a_idx)*AW +: AW];
        DIA  <= wdata[32'(a_idx)*DW +: DW];
      end
      CSB  <= b_hit;
      WEBN <= ~(b_hit & we[b_idx]);
      if (b_hit) begin
        B_in <= addr[32'(b_idx)*AW +: AW];
        DIB  <= wdata[32'(b_idx)*DW +: DW];
      end

      rd_a     <= a_hit & ~we[a_idx];
      rd_b     <= b_hit & ~we[b_idx];
      rd_a_idx <= a_idx;
      rd_b_idx <= b_idx;

      // Controller data is valid during the issue cycle; capture it at the end of that cycle.
      rvalid <= '0;
      if (rd_a) begin
        rvalid[rd_a_idx]                <= 1'b1;
        rdata[32'(rd_a_idx)*DW +: DW]   <= DOA;
      end
      if (rd_b) begin
        rvalid[rd_b_idx]                <= 1'b1;
        rdata[32'(rd_b_idx)*DW +: DW]   <= DOB;
      end
    end
  end
endmodule

// File: tb/tb_pazen_mem_arbiter.sv
// Bench for pazen_mem_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue-based arbitration and memory model.
module tb_pazen_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;

  logic            clk, reset, preload;
  logic [N-1:0]    req, we, gnt, rvalid;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata, rdata;
  logic [AW-1:0]   A_in, B_in;
  logic [DW-1:0]   DIA, DIB, DOA, DOB;
  logic            CSA, CSB, WEAN, WEBN;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] last_gnt = '0;

  pazen_mem_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .A_in(A_in), .B_in(B_in), .DIA(DIA), .DIB(DIB),
    .CSA(CSA), .CSB(CSB), .WEAN(WEAN), .WEBN(WEBN), .DOA(DOA), .DOB(DOB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] init_word(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {b, ~b};
  endfunction

  // Controller: combinational read, write at the end of the issue cycle.
  logic [DW-1:0] ctrl_mem [256];
  assign DOA = ctrl_mem[A_in];
  assign DOB = ctrl_mem[B_in];
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 256; a++) ctrl_mem[a] <= init_word(a);
    end else begin
      if (CSA && !WEAN) ctrl_mem[A_in] <= DIA;
      if (CSB && !WEBN) ctrl_mem[B_in] <= DIB;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model
  int              m_ptr = 0;
  logic            m_csa = 1'b0, m_csb = 1'b0, m_wean = 1'b1, m_webn = 1'b1;
  logic [AW-1:0]   m_ain = '0, m_bin = '0;
  logic [DW-1:0]   m_dia = '0, m_dib = '0;
  logic [N-1:0]    m_rvalid = '0, s1_valid = '0;
  logic [N*DW-1:0] m_rdata = '0, s1_data = '0;
  logic [DW-1:0]   ref_mem [256];

  function automatic logic [AW-3:0] line_of(input int i);
    return addr[i*AW + 2 +: AW-2];
  endfunction

  initial begin
    int order[$];
    int wa, wb, j;
    logic [N-1:0] eg;
    for (int a = 0; a < 256; a++) ref_mem[a] = init_word(a);
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("csa", CSA, m_csa);
      chk("csb", CSB, m_csb);
      chk("wean", WEAN, m_wean);
      chk("webn", WEBN, m_webn);
      chk("a_in", A_in, m_ain);
      chk("b_in", B_in, m_bin);
      chk("dia", DIA, m_dia);
      chk("dib", DIB, m_dib);
      chk("rvalid", rvalid, m_rvalid);
      chk("rdata", rdata, m_rdata);

      order = {};
      for (int k = 0; k < N; k++)
        if (req[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
      wa = -1;
      wb = -1;
      if (!reset && order.size() > 0) begin
        wa = order[0];
        for (int k = 1; k < order.size(); k++) begin
          j = order[k];
          if (wb < 0 && !(line_of(j) == line_of(wa) && (we[j] || we[wa]))) wb = j;
        end
      end
      eg = '0;
      if (wa >= 0) eg[wa] = 1'b1;
      if (wb >= 0) eg[wb] = 1'b1;
      chk("gnt", gnt, eg);
      last_gnt = gnt;

      if (reset) begin
        m_ptr = 0; m_csa = 1'b0; m_csb = 1'b0; m_wean = 1'b1; m_webn = 1'b1;
        m_ain = '0; m_bin = '0; m_dia = '0; m_dib = '0;
        m_rvalid = '0; m_rdata = '0; s1_valid = '0; s1_data = '0;
      end else begin
        m_rvalid = s1_valid;
        for (int i = 0; i < N; i++)
          if (s1_valid[i]) m_rdata[i*DW +: DW] = s1_data[i*DW +: DW];
        s1_valid = '0;
        for (int i = 0; i < N; i++)
          if (eg[i] && !we[i]) begin
            s1_valid[i] = 1'b1;
            s1_data[i*DW +: DW] = ref_mem[addr[i*AW +: AW]];
          end
        for (int i = 0; i < N; i++)
          if (eg[i] && we[i]) ref_mem[addr[i*AW +: AW]] = wdata[i*DW +: DW];
        m_csa  = (wa >= 0);
        m_csb  = (wb >= 0);
        m_wean = !(wa >= 0 && we[wa]);
        m_webn = !(wb >= 0 && we[wb]);
        if (wa >= 0) begin m_ain = addr[wa*AW +: AW]; m_dia = wdata[wa*DW +: DW]; end
        if (wb >= 0) begin m_bin = addr[wb*AW +: AW]; m_dib = wdata[wb*DW +: DW]; end
        if (wa >= 0) m_ptr = ((wb >= 0 ? wb : wa) + 1) % N;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = 1'b1;
    we[i] = w;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    preload = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i*4), '0);
    step();
    preload = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_gnt", gnt, 4'b0000);
      chk("rst_cs", {CSA, CSB}, 2'b00);
      chk("rst_wen", {WEAN, WEBN}, 2'b11);
      chk("rst_rvalid", rvalid, 4'b0000);
    end
    step();
    reset = 1'b0;
    req = '0;

    // write then read of word 45
    set_req(0, 1'b1, 8'd45, 16'hBEEF);
    @(negedge clk); chk("t2_gnt_wr", gnt, 4'b0001);
    step(); set_req(0, 1'b0, 8'd45, '0);
    @(negedge clk); chk("t2_gnt_rd", gnt, 4'b0001);
    chk("t2_iss_wr", {CSA, WEAN, A_in, DIA}, {1'b1, 1'b0, 8'd45, 16'hBEEF});
    step(); req = '0;
    @(negedge clk); chk("t2_iss_rd", {CSA, WEAN, A_in}, {1'b1, 1'b1, 8'd45});
    chk("t2_no_early_rvalid", rvalid, 4'b0000);
    @(negedge clk); chk("t2_rvalid", rvalid, 4'b0001);
    chk("t2_rdata", rdata[15:0], 16'hBEEF);

    // move rr_ptr to 0 by granting requester 3
    step(); set_req(3, 1'b0, 8'd0, '0);
    @(negedge clk); chk("t4_prep_gnt", gnt, 4'b1000);
    step(); req = '0;

    // same-line write/read conflict
    set_req(1, 1'b1, 8'd8, 16'h5A5A);
    set_req(2, 1'b0, 8'd10, '0);
    @(negedge clk); chk("t4_gnt1", gnt, 4'b0010);
    step(); req[1] = 1'b0;
    @(negedge clk); chk("t4_gnt2", gnt, 4'b0100);
    chk("t4_iss", {CSA, CSB, WEAN, A_in}, {1'b1, 1'b0, 1'b0, 8'd8});
    step(); req = '0;
    @(negedge clk); chk("t4_iss2", {CSA, CSB, A_in}, {1'b1, 1'b0, 8'd10});
    @(negedge clk); chk("t4_rvalid", rvalid, 4'b0100);
    chk("t4_rdata", rdata[47:32], 16'h0AF5);

    // two reads of the same word together
    step(); set_req(0, 1'b0, 8'd250, '0); set_req(3, 1'b0, 8'd250, '0);
    @(negedge clk); chk("t5_gnt", gnt, 4'b1001);
    step(); req = '0;
    @(negedge clk); chk("t5_iss", {CSA, CSB, A_in, B_in}, {1'b1, 1'b1, 8'd250, 8'd250});
    @(negedge clk); chk("t5_rvalid", rvalid, 4'b1001);
    chk("t5_rdata0", rdata[15:0], 16'hFA05);
    chk("t5_rdata3", rdata[63:48], 16'hFA05);

    // reset right after a read grant drops the read
    step(); set_req(1, 1'b0, 8'd3, '0);
    @(negedge clk); chk("t6_gnt", gnt, 4'b0010);
    step(); req = '0; reset = 1'b1;
    repeat (3) begin
      @(negedge clk); chk("t6_no_rvalid", rvalid, 4'b0000);
    end
    step(); reset = 1'b0;

    // all four reading distinct lines continuously
    for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(100 + i*4), '0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t3_gnt", gnt, (c % 2 == 0) ? 4'b0011 : 4'b1100);
      pulses += $countones(rvalid);
      step();
    end
    req = '0;
    repeat (3) begin
      @(negedge clk);
      pulses += $countones(rvalid);
      step();
    end
    chk("t3_pulses", 64'(pulses), 64'd16);

    // random traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      reset = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i] && last_gnt[i]) req[i] = 1'b0;
        if (!req[i] && $urandom_range(0, 9) < 6)
          set_req(i, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 11)),
                  DW'($urandom));
      end
    end
    step();
    reset = 1'b0;
    req = '0;
    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
